apx_seq_alu: RTL and testbench
==============================

Name: apx_seq_alu

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU, registered at its output.
- Adds an iterative exact multiplier and an iterative approximate (operand-truncated) multiplier.
- Generalises the segmented approximate adder by data width, exact-LSB span and segment width.
- Sits between the operand MUX and writeback; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- APX_EXACT_LSB, 8, low bits computed exactly by ADD_APX; must be ≤ WIDTH.
- APX_SEG, 2, carry-isolated segment width above APX_EXACT_LSB; (WIDTH−APX_EXACT_LSB) % APX_SEG == 0.
- APX_TRUNC, 4, low operand bits forced to 0 by MUL_APX; 0 ≤ APX_TRUNC < WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when a request can be accepted.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADD_APX, 6 MUL, 7 MUL_APX.
- read_a  in  WIDTH  operand A.
- read_x  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- busy  out  1  high in state BUSY.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset sets state to IDLE, result=0, out_valid=0, busy=0 and clears the iteration counter and accumulator. Reset has priority at any point, including mid-multiply or mid-DONE; any in-flight op is discarded and produces no result.
- in_ready = (state==IDLE) && !reset. A request is accepted on an edge where in_valid && in_ready; op and operands are captured on that edge and later changes are ignored.
- Single-cycle ops (0–5): IDLE→DONE on the accept edge; result and out_valid appear at edge k+1 after accept edge k.
- ADD, SUB, AND, OR, XOR: modulo 2^WIDTH; SUB wraps and has no flags.
- ADD_APX: bits [APX_EXACT_LSB−1:0] = (a+b) mod 2^APX_EXACT_LSB. Each following APX_SEG-bit segment = (a_seg+b_seg) mod 2^APX_SEG. Every carry out of each region is dropped.
- MUL: shift-add, one multiplier bit per cycle, LSB first. The accept edge loads the accumulator=0, the multiplicand and the multiplier. Then IDLE→BUSY and the design stays in BUSY for WIDTH iterations. result = low WIDTH bits of a*b, and out_valid rises at edge k+WIDTH+1.
- MUL_APX: the low APX_TRUNC bits of both operands are zeroed. Iteration starts at multiplier bit APX_TRUNC, giving WIDTH−APX_TRUNC iterations. out_valid rises at edge k+WIDTH−APX_TRUNC+1. result = ((a&~m)*(b&~m)) mod 2^WIDTH, with m = 2^APX_TRUNC−1.
- DONE: result and out_valid are held stable while !out_ready.
  - On out_valid && out_ready: DONE→IDLE, out_valid=0, result retains its value.
  - There is no back-to-back accept in the handover cycle; at most one op is in flight.
- Illegal parameter combinations are not required to be detected in RTL, but the bench must not use them.

Optional Feature:
- Macro: APX_SEQ_ALU_EARLY_EXIT_EN.
- When defined, MUL and MUL_APX leave BUSY at the end of the first iteration after which the remaining (unshifted) multiplier bits are all zero. A zero multiplier completes after 1 iteration. The result is bit-identical to the non-early-exit result.
- When not defined, MUL and MUL_APX use the fixed latencies above.

Test Plan:
- Reset during BUSY: MUL 0x1234×0x10 accepted, reset asserted 5 cycles later → next edge: out_valid=0, result=0, in_ready=1; out_valid never rises for that op.
- ADD vs ADD_APX (defaults):
  - ADD 0xFF+0x01 → 0x100.
  - ADD_APX 0xFF+0x01 → 0x00000000.
  - ADD_APX 0x300+0x100 → 0x00000000.
  - ADD_APX 0x00000107+0x00000201 → 0x00000308.
  - All four with 1-cycle latency.
- SUB 0x0+0x1 and XOR 0xF0F0F0F0^0xFFFFFFFF → 0xFFFFFFFF and 0x0F0F0F0F.
- MUL 0x00001234×0x00000010 → 0x00012340, out_valid exactly 33 edges after accept (no macro); in_ready=0 and busy=1 throughout.
- MUL_APX 0x13×0x25 (APX_TRUNC=4) → 0x00000200, latency 29 edges.
- Backpressure: out_ready=0 for 10 cycles in DONE → result stable, in_ready=0; pulse out_ready → IDLE next edge.
- With APX_SEQ_ALU_EARLY_EXIT_EN: MUL 0x1234×0x10 → 0x12340 after 6 edges; multiplier 0 → result 0 after 2 edges.

Source files
------------

// File: rtl/apx_seq_alu.sv
// Handshaked, output-registered ALU with exact/approximate add and iterative exact/truncated multipliers.
// Define APX_SEQ_ALU_EARLY_EXIT_EN to end multiplies once the remaining multiplier bits are all zero.
module apx_seq_alu #(
  parameter int WIDTH         = 32,
  parameter int APX_EXACT_LSB = 8,
  parameter int APX_SEG       = 2,
  parameter int APX_TRUNC     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] read_a,
  input  logic [WIDTH-1:0] read_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] KEEP_MASK = ~((WIDTH'(1) << APX_TRUNC) - WIDTH'(1));
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_ADD_APX = 3'd5, OP_MUL = 3'd6, OP_MUL_APX = 3'd7;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_last;
  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic             w_iter_end;

  // Low region exact, then each segment adds with its carry-in and carry-out cut.
  function automatic logic [WIDTH-1:0] f_add_apx(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] s;
    m = '0;
    for (int i = 0; i < APX_EXACT_LSB; i++) m[i] = 1'b1;
    s = ((a & m) + (b & m)) & m;
    for (int i = APX_EXACT_LSB; i < WIDTH; i += APX_SEG) begin
      m = '0;
      for (int j = 0; j < APX_SEG; j++) if (i + j < WIDTH) m[i+j] = 1'b1;
      s = s | (((a & m) + (b & m)) & m);
    end
    return s;
  endfunction

  always_comb begin
    w_alu = r_acc;
    case (r_op)
      OP_ADD:     w_alu = r_a + r_b;
      OP_SUB:     w_alu = r_a - r_b;
      OP_AND:     w_alu = r_a & r_b;
      OP_OR:      w_alu = r_a | r_b;
      OP_XOR:     w_alu = r_a ^ r_b;
      OP_ADD_APX: w_alu = f_add_apx(r_a, r_b);
      default:    w_alu = r_acc;
    endcase
  end

  assign w_acc_nxt    = r_acc + (r_b[0] ? r_a : '0);
  assign w_mplier_nxt = r_b >> 1;

`ifdef APX_SEQ_ALU_EARLY_EXIT_EN
  assign w_iter_end = (r_cnt == r_last) || (w_mplier_nxt == '0);
`else
  assign w_iter_end = (r_cnt == r_last);
`endif

  // DONE spends its first cycle registering the result, which gives the k+1 / k+N+1 latencies.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_last      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= op;
            r_acc <= '0;
            r_cnt <= '0;
            if (op == OP_MUL) begin
              r_a     <= read_a;
              r_b     <= read_x;
              r_last  <= CW'(WIDTH - 1);
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end else if (op == OP_MUL_APX) begin
              // Pre-align so iteration 0 handles multiplier bit APX_TRUNC.
              r_a     <= (read_a & KEEP_MASK) << APX_TRUNC;
              r_b     <= read_x >> APX_TRUNC;
              r_last  <= CW'(WIDTH - APX_TRUNC - 1);
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end else begin
              r_a     <= read_a;
              r_b     <= read_x;
              r_state <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= w_mplier_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_iter_end) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_result    <= w_alu;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_apx_seq_alu.sv
// Scoreboard bench for apx_seq_alu at default parameters; latency model follows APX_SEQ_ALU_EARLY_EXIT_EN.
module tb_apx_seq_alu;
  localparam int W = 32, L = 8, SEG = 2, T = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]   op;
  logic [W-1:0] read_a, read_x, result;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apx_seq_alu #(.WIDTH(W), .APX_EXACT_LSB(L), .APX_SEG(SEG), .APX_TRUNC(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .read_a(read_a), .read_x(read_x), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] s;
    logic [W-1:0] m;
    logic         c;
    s = '0;
    m = ~((W'(1) << T) - W'(1));
    case (o)
      3'd0: s = a + b;
      3'd1: s = a - b;
      3'd2: s = a & b;
      3'd3: s = a | b;
      3'd4: s = a ^ b;
      3'd5: begin
        c = 1'b0;
        for (int i = 0; i < W; i++) begin
          if (i == L || (i > L && ((i - L) % SEG) == 0)) c = 1'b0;
          s[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
      end
      3'd6: s = a * b;
      default: s = (a & m) * (b & m);
    endcase
    return s;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] b);
    logic [W-1:0] bb;
    int it;
    if (o < 3'd6) return 1;
    bb = (o == 3'd7) ? (b >> T) : b;
    it = (o == 3'd7) ? (W - T) : W;
`ifdef APX_SEQ_ALU_EARLY_EXIT_EN
    begin
      int k;
      k = 1;
      for (int i = 0; i < W; i++) if (bb[i]) k = i + 1;
      if (k < it) it = k;
    end
`else
    if (bb === 'x) it = 0;
`endif
    return it + 1;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input string tag);
    exp_t         e;
    exp_t         got_e;
    int           n;
    logic         stall_ok;
    logic         hold_ok;
    logic [W-1:0] r0;
    @(negedge clk);
    op = o; read_a = a; read_x = b; in_valid = 1'b1;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    e.res = model_res(o, a, b);
    e.lat = model_lat(o, b);
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); read_a = $urandom; read_x = $urandom;
    n = 0;
    stall_ok = 1'b1;
    while (!out_valid && n < 200) begin
      if (in_ready) stall_ok = 1'b0;
      if (o >= 3'd6 && n < e.lat - 1 && !busy) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    got_e = sb.pop_front();
    chk({tag, "_result"}, result, got_e.res);
    chk({tag, "_latency"}, W'(n), W'(got_e.lat));
    chk({tag, "_stall"}, W'(stall_ok), W'(1));
    if (hold > 0) begin
      r0 = result;
      hold_ok = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || result !== r0) hold_ok = 1'b0;
      end
      chk({tag, "_hold"}, W'(hold_ok), W'(1));
    end
    r0 = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_release"}, {W'(out_valid), W'(in_ready)} >> 0 == 0 ? W'(0) : {out_valid, in_ready, 30'b0},
        {1'b0, 1'b1, 30'b0});
    chk({tag, "_retain"}, result, r0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; read_a = '0; read_x = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready_held", W'(in_ready), W'(0));
    reset = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Reset mid-multiply discards the op.
    @(negedge clk);
    op = 3'd6; read_a = 32'h1234; read_x = 32'h10; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{res: 32'h12340, lat: model_lat(3'd6, 32'h10)});
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 reset = 1'b0;
    #1;
    chk("rstbusy_out_valid", W'(out_valid), W'(0));
    chk("rstbusy_result", result, W'(0));
    chk("rstbusy_in_ready", W'(in_ready), W'(1));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rstbusy_no_result", W'(seen), W'(0));

    do_op(3'd0, 32'hFF, 32'h01, 0, "add_ff");
    chk("add_ff_const", result, 32'h100);
    do_op(3'd5, 32'hFF, 32'h01, 0, "apx_ff");
    chk("apx_ff_const", result, 32'h0);
    do_op(3'd5, 32'h300, 32'h100, 0, "apx_300");
    chk("apx_300_const", result, 32'h0);
    do_op(3'd5, 32'h107, 32'h201, 0, "apx_107");
    chk("apx_107_const", result, 32'h308);
    do_op(3'd1, 32'h0, 32'h1, 0, "sub_wrap");
    chk("sub_wrap_const", result, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 0, "xor");
    chk("xor_const", result, 32'h0F0F_0F0F);
    do_op(3'd2, 32'hDEAD_BEEF, 32'h0F0F_FF00, 0, "and");
    do_op(3'd3, 32'h1200_0034, 32'h0056_7800, 0, "or");
    do_op(3'd6, 32'h1234, 32'h10, 0, "mul");
    chk("mul_const", result, 32'h12340);
    do_op(3'd6, 32'hFFFF_FFFF, 32'h0, 0, "mul_zero");
    do_op(3'd6, 32'hFFFF_FFFF, 32'h8000_0001, 0, "mul_msb");
    do_op(3'd7, 32'h13, 32'h25, 0, "mulapx");
    chk("mulapx_const", result, 32'h200);
    do_op(3'd7, 32'hFFFF, 32'hF, 0, "mulapx_trunc0");
    do_op(3'd0, 32'hAAAA_5555, 32'h1111_2222, 10, "backpr");
    do_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 3, "mulapx_bp");

    for (int i = 0; i < 16; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? W'($urandom_range(0, 255)) : $urandom;
      do_op(ro, ra, rb, i % 3, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
